// File: rtl/uart_tx_os_if.sv
// uart_tx_os_if: parallel-load handshake, oversampling tick and serial line of uart_tx_os.
interface uart_tx_os_if #(
    parameter int DBIT = 8
);
    logic            tx_start;
    logic            s_tick;
    logic [DBIT-1:0] din;
    logic            tx_busy;
    logic            tx_done_tick;
    logic            tx;
    modport master(output tx_start, s_tick, din, input tx_busy, tx_done_tick, tx);
    modport slave(input tx_start, s_tick, din, output tx_busy, tx_done_tick, tx);
endinterface

// File: rtl/uart_tx_os.sv
// uart_tx_os: 16x-oversampled UART transmitter (start, DBIT data bits LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_os #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input logic         clk,
    input logic         reset,
    uart_tx_os_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t          r_state, w_state;
    logic [4:0]      r_s, w_s;
    logic [3:0]      r_n, w_n;
    logic [DBIT-1:0] r_b, w_b;
    logic            r_tx, w_tx;
    logic            r_done, w_done;
`ifdef UART_TX_PARITY_EN
    logic            r_p, w_p;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_p     <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_n     <= w_n;
            r_b     <= w_b;
            r_tx    <= w_tx;
            r_done  <= w_done;
`ifdef UART_TX_PARITY_EN
            r_p     <= w_p;
`endif
        end
    end
    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_b     = r_b;
        w_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_p     = r_p;
`endif
        case (r_state)
            IDLE: if (bus.tx_start) begin
                w_b     = bus.din;
                w_s     = 5'd0;
                w_state = START;
`ifdef UART_TX_PARITY_EN
                w_p     = ^bus.din;
`endif
            end
            START: if (bus.s_tick) begin
                if (r_s == 5'd15) begin
                    w_s     = 5'd0;
                    w_n     = 4'd0;
                    w_state = DATA;
                end else w_s = r_s + 5'd1;
            end
            DATA: if (bus.s_tick) begin
                if (r_s == 5'd15) begin
                    w_s = 5'd0;
                    w_b = r_b >> 1;
                    if (r_n == 4'(DBIT - 1))
`ifdef UART_TX_PARITY_EN
                        w_state = PARITY;
`else
                        w_state = STOP;
`endif
                    else w_n = r_n + 4'd1;
                end else w_s = r_s + 5'd1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bus.s_tick) begin
                if (r_s == 5'd15) begin
                    w_s     = 5'd0;
                    w_state = STOP;
                end else w_s = r_s + 5'd1;
            end
`endif
            STOP: if (bus.s_tick) begin
                if (r_s == 5'(SB_TICK - 1)) begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                end else w_s = r_s + 5'd1;
            end
            default: w_state = IDLE;
        endcase
        // line level follows the state being entered so tx moves on the transition edge
`ifdef UART_TX_PARITY_EN
        w_tx = (w_state == START) ? 1'b0 : (w_state == DATA) ? w_b[0] : (w_state == PARITY) ? w_p : 1'b1;
`else
        w_tx = (w_state == START) ? 1'b0 : (w_state == DATA) ? w_b[0] : 1'b1;
`endif
    end
    assign bus.tx           = r_tx;
    assign bus.tx_busy      = (r_state != IDLE);
    assign bus.tx_done_tick = r_done;
endmodule

// File: tb/tb_uart_tx_os.sv
// tb_uart_tx_os: directed frames on a SB_TICK=16 instance (tick every 16 clk) and a SB_TICK=32 instance (tick tied high).
module tb_uart_tx_os;
`ifdef UART_TX_PARITY_EN
    localparam int NS = 11;
    localparam int FT = 176;
    localparam int PO = 16;
`else
    localparam int NS = 10;
    localparam int FT = 160;
    localparam int PO = 0;
`endif
    logic clk = 1'b0;
    logic rst0, rst1;
    int n_chk = 0, n_pass = 0;
    int ticks = 0, phase = 0;
    bit ticked;
    uart_tx_os_if #(.DBIT(8)) b0 ();
    uart_tx_os_if #(.DBIT(8)) b1 ();
    uart_tx_os #(.DBIT(8), .SB_TICK(16)) u0 (.clk(clk), .reset(rst0), .bus(b0.slave));
    uart_tx_os #(.DBIT(8), .SB_TICK(32)) u1 (.clk(clk), .reset(rst1), .bus(b1.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic cyc();
        bit t;
        t = b0.s_tick;
        @(posedge clk);
        #1;
        ticked = t;
        if (t) ticks++;
        phase = (phase + 1) % 16;
        b0.s_tick = (phase == 0);
    endtask
    task automatic accept(input logic [7:0] d);
        b0.din = d;
        b0.tx_start = 1'b1;
        cyc();
        b0.tx_start = 1'b0;
        ticks = 0;
    endtask
    // follows one frame from its accept edge to the done cycle; inj >= 0 pulses tx_start/0xFF at that tick
    task automatic watch(input string tag, input logic [7:0] d, input logic p, input int inj);
        logic [10:0] got, exp;
        int busy_bad, done_at, inj_st;
        got = '0;
        busy_bad = 0;
        done_at = -1;
        inj_st = 0;
        exp = (NS == 11) ? {1'b1, p, d, 1'b0} : {2'b01, d, 1'b0};
        for (int c = 0; c < 5000 && done_at < 0; c++) begin
            cyc();
            if (inj_st == 1) begin
                b0.tx_start = 1'b0;
                inj_st = 2;
            end
            if (ticked && ticks % 16 == 8 && ticks / 16 < NS) got[ticks / 16] = b0.tx;
            if (b0.tx_done_tick) done_at = ticks;
            else if (!b0.tx_busy) busy_bad++;
            if (inj_st == 0 && inj >= 0 && ticks == inj) begin
                b0.tx_start = 1'b1;
                b0.din = 8'hFF;
                inj_st = 1;
            end
        end
        chk({tag, " bits"}, 32'(got), 32'(exp));
        chk({tag, " done_at"}, done_at, FT);
        chk({tag, " busy"}, busy_bad, 0);
    endtask
    task automatic count_done(input string tag, input int n);
        int nd;
        nd = 0;
        for (int c = 0; c < n; c++) begin
            cyc();
            if (b0.tx_done_tick) nd++;
        end
        chk({tag, " extra done"}, nd, 0);
    endtask
    initial begin
        int rise, dn, low_after;
        rst0 = 1'b1;
        rst1 = 1'b1;
        b0.tx_start = 1'b0;
        b0.s_tick = 1'b0;
        b0.din = '0;
        b1.tx_start = 1'b0;
        b1.s_tick = 1'b1;
        b1.din = '0;
        cyc();
        cyc();
        chk("rst tx", b0.tx, 1);
        chk("rst busy", b0.tx_busy, 0);
        chk("rst done", b0.tx_done_tick, 0);
        chk("rst1 tx", b1.tx, 1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        cyc();
        accept(8'hA5);
        chk("A5 start tx", b0.tx, 0);
        chk("A5 start busy", b0.tx_busy, 1);
        watch("A5", 8'hA5, 1'b0, -1);
        cyc();
        chk("A5 done width", b0.tx_done_tick, 0);
        chk("A5 idle tx", b0.tx, 1);
        accept(8'h3C);
        watch("3C lockout", 8'h3C, 1'b0, 40);
        count_done("3C", 3000);
        chk("3C idle busy", b0.tx_busy, 0);
        b0.din = 8'h01;
        b0.tx_start = 1'b1;
        cyc();
        ticks = 0;
        b0.din = 8'h80;
        watch("b2b 01", 8'h01, 1'b1, -1);
        cyc();
        b0.tx_start = 1'b0;
        ticks = 0;
        chk("b2b gap done", b0.tx_done_tick, 0);
        chk("b2b gap busy", b0.tx_busy, 1);
        chk("b2b gap tx", b0.tx, 0);
        watch("b2b 80", 8'h80, 1'b1, -1);
        cyc();
        chk("b2b end busy", b0.tx_busy, 0);
        accept(8'h55);
        for (int c = 0; c < 3000 && ticks < 70; c++) cyc();
        rst0 = 1'b1;
        cyc();
        rst0 = 1'b0;
        chk("midrst tx", b0.tx, 1);
        chk("midrst busy", b0.tx_busy, 0);
        chk("midrst done", b0.tx_done_tick, 0);
        count_done("midrst", 3000);
        accept(8'h55);
        watch("55 after rst", 8'h55, 1'b0, -1);
        cyc();
        accept(8'hA4);
        watch("A4", 8'hA4, 1'b1, -1);
        cyc();
        b1.din = 8'h00;
        b1.tx_start = 1'b1;
        cyc();
        b1.tx_start = 1'b0;
        chk("sb32 start tx", b1.tx, 0);
        rise = -1;
        dn = -1;
        low_after = 0;
        for (int k = 1; k <= 400 && dn < 0; k++) begin
            cyc();
            if (rise < 0 && b1.tx) rise = k;
            if (b1.tx_done_tick) dn = k;
            else if (rise >= 0 && !b1.tx) low_after++;
        end
        chk("sb32 stop rise", rise, 144 + PO);
        chk("sb32 done", dn, 176 + PO);
        chk("sb32 stop held", low_after, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_os.md
Name: uart_tx_os

Overview:
- UART serial transmitter, the transmit-side consumer of the oversampling baud tick from the mod-M baud generator.
- Accepts a parallel byte with a start strobe and serialises it onto `tx` as: start bit, DBIT data bits LSB first, optional parity bit, stop bit(s).
- Each bit lasts 16 `s_tick` pulses (16x oversampling); stop length is SB_TICK ticks.

Parameters:
- DBIT, 8, data bits per frame; legal range 5..9.
- SB_TICK, 16, stop duration in ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2; legal range 16..32.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_start  input  1  request to send `din`; sampled only in IDLE.
- s_tick  input  1  one-clk-wide oversampling tick (16x baud) from the baud generator.
- din  input  DBIT  data to transmit; captured on the accepted `tx_start` cycle.
- tx_busy  output  1  high whenever state != IDLE.
- tx_done_tick  output  1  one-clk pulse marking frame completion.
- tx  output  1  serial line; registered, idles high.

Behaviour:
- Internal registers:
  - state.
  - s_reg, 5 bits: tick count within current bit.
  - n_reg, 4 bits: data bit index.
  - b_reg, DBIT bits: shift register.
  - tx_reg; tx_done_reg.
- Reset (synchronous, highest priority):
  - state = IDLE; s_reg, n_reg, b_reg = 0.
  - tx = 1, tx_busy = 0, tx_done_tick = 0.
- `tx` is registered from a next-value computed from the next state. The line changes on the same edge as the state transition, with no combinational path to the pin.
- IDLE (tx = 1):
  - `s_tick` is ignored.
  - If `tx_start` = 1: b_reg <= din, s_reg <= 0, go to START.
- START (tx = 0): on `s_tick`, if s_reg == 15 then s_reg <= 0, n_reg <= 0, go to DATA; else s_reg++.
- DATA (tx = b_reg[0]): on `s_tick`, if s_reg == 15:
  - s_reg <= 0; b_reg shifts right by 1.
  - If n_reg == DBIT-1, go to STOP (or PARITY when enabled); else n_reg++.
  - Otherwise s_reg++.
- STOP (tx = 1): on `s_tick`, if s_reg == SB_TICK-1 then go to IDLE and set tx_done_reg <= 1; else s_reg++.
- `tx_done_tick` timing:
  - High for exactly one clk.
  - That clk is the first cycle in IDLE after the final stop tick; it is otherwise 0.
- Clock cycles without `s_tick` hold all counters; `s_tick` held continuously high advances one count per clk.
- `tx_start` while busy is ignored. `din` changes after capture have no effect on the frame in flight.
- Back-to-back frames: `tx_start` asserted in the `tx_done_tick` cycle is accepted, so START begins on the following edge with no extra idle tick.
- Reset mid-frame:
  - The frame is abandoned and `tx` returns to 1 at that edge.
  - No `tx_done_tick` is produced.
- Frame length (no parity): 16*(1+DBIT) + SB_TICK ticks.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity: XOR of all DBIT bits of the captured `din`, held in a 1-bit register computed at capture.
  - PARITY lasts 16 ticks, using the same s_reg rules as a data bit.
  - Frame length grows by 16 ticks.
- When undefined: the PARITY state and the parity register do not exist, and DATA goes directly to STOP.

Test Plan:
- Single frame: DBIT=8, SB_TICK=16, `s_tick` every 16 clk, din=0xA5, `tx_start` pulse.
  - `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks.
  - `tx_done_tick` is one clk, 160 ticks after start.
  - `tx_busy` is high throughout the frame.
- Busy lockout: din=0x3C is sent; `tx_start` with din=0xFF is pulsed mid-data.
  - The line carries only 0x3C.
  - Exactly one `tx_done_tick` occurs.
- Back-to-back: `tx_start` held high with din=0x01, then 0x80.
  - Two contiguous frames with no idle gap beyond the done cycle.
  - Two `tx_done_tick` pulses, 160 ticks apart.
- Reset mid-frame: reset for 1 clk during bit 3 of 0x55.
  - tx=1 and tx_busy=0 on the next edge; no done pulse.
  - A following `tx_start` with 0x55 transmits a full correct frame.
- Stop length: SB_TICK=32, din=0x00, `s_tick` tied high.
  - Stop high for 32 clk; done 176 clk after start.
- Parity (UART_TX_PARITY_EN defined): din=0xA5 gives parity bit 0; din=0xA4 gives parity bit 1.
  - Frame is 176 ticks with SB_TICK=16.
